tetris_cmd_sched: RTL and testbench

//  Command scheduler in front of the tetris engine. Latches button pulses, gravity ticks and garbage-bar requests,

---
 rtl/tetris_cmd_sched_if.sv | 24 ++
 rtl/tetris_cmd_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_tetris_cmd_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_cmd_sched_if.sv
// rtl/tetris_cmd_sched_if.sv - engine/input/command bus of the tetris command scheduler
interface tetris_cmd_sched_if;
  // Engine and player side
  logic [3:0]  eng_state;
  logic [15:0] score;
  logic [7:0]  btn_evt;
  logic        bar_req;
  logic        pause;
  // Scheduler side
  logic [3:0]  ctrl;
  logic [9:0]  bar_mask;
  logic [3:0]  level;
  logic        busy;

  modport master (
    output eng_state, score, btn_evt, bar_req, pause,
    input  ctrl, bar_mask, level, busy
  );

  modport slave (
    input  eng_state, score, btn_evt, bar_req, pause,
    output ctrl, bar_mask, level, busy
  );
endinterface

// File: rtl/tetris_cmd_sched.sv
// rtl/tetris_cmd_sched.sv - request latching, arbitration, gravity and garbage-row generation for the tetris engine
module tetris_cmd_sched #(
  parameter logic [31:0] GRAV_BASE = 32'd50_000_000,
  parameter logic [31:0] GRAV_STEP = 32'd4_500_000,
  parameter logic [31:0] GRAV_MIN  = 32'd5_000_000,
  parameter logic [4:0]  BAR_MAX   = 5'd20
) (
  input logic               clk,
  input logic               reset_n,
  tetris_cmd_sched_if.slave bus
);

  // Shared engine-state / command encoding (values >= 12 are engine working states)
  localparam logic [3:0] ST_NONE       = 4'd0;
  localparam logic [3:0] ST_LEFT       = 4'd1;
  localparam logic [3:0] ST_RIGHT      = 4'd2;
  localparam logic [3:0] ST_ROTATE     = 4'd3;
  localparam logic [3:0] ST_ROTATE_REV = 4'd4;
  localparam logic [3:0] ST_DOWN       = 4'd5;
  localparam logic [3:0] ST_DROP       = 4'd6;
  localparam logic [3:0] ST_HOLD       = 4'd7;
  localparam logic [3:0] ST_BAR        = 4'd8;
  localparam logic [3:0] ST_INIT       = 4'd9;
  localparam logic [3:0] ST_WAIT       = 4'd10;
  localparam logic [3:0] ST_END        = 4'd11;

  // Button pulse bit positions
  localparam int B_LEFT       = 0;
  localparam int B_RIGHT      = 1;
  localparam int B_ROTATE     = 2;
  localparam int B_ROTATE_REV = 3;
  localparam int B_DOWN       = 4;
  localparam int B_DROP       = 5;
  localparam int B_HOLD       = 6;
  localparam int B_START      = 7;

  localparam logic [9:0] LFSR_SEED = 10'h2A5;

  typedef enum logic [1:0] {IDLE, READY, ISSUED, BUSY} fsm_t;

  fsm_t        state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        busy_d;
  logic [9:0]  bar_mask_q;
  logic [3:0]  level_q, level_d;

  // Pending request flags
  logic        drop_q, hold_q, rot_q, rot_rev_q, left_q, right_q, down_q;
  logic [4:0]  bar_cnt_q;
  logic [31:0] grav_cnt_q;
  logic [9:0]  lfsr_q;

  logic        eng_wait, eng_off;
  logic [31:0] grav_dec, grav_period;
  logic        grav_run, grav_tick, down_req;
  logic        can_issue, issue;
  logic [3:0]  sel_cmd;
  logic        iss_drop, iss_hold, iss_rot, iss_rot_rev, iss_left, iss_right, iss_down, iss_bar;
  logic        left_n, right_n;
  logic [9:0]  lfsr_mod, bar_row;
  logic        unused_score;

  assign eng_wait = (bus.eng_state == ST_WAIT);
  assign eng_off  = (bus.eng_state == ST_INIT) || (bus.eng_state == ST_END);

  // Only the BCD hundreds digit drives the level; a non-decimal digit is treated as 9
  assign level_d      = (bus.score[11:8] > 4'd9) ? 4'd9 : bus.score[11:8];
  assign unused_score = ^{bus.score[15:12], bus.score[7:0]};

  // Gravity period shrinks with level and saturates at the floor
  assign grav_dec    = 32'(level_q) * GRAV_STEP;
  assign grav_period = (grav_dec >= GRAV_BASE - GRAV_MIN) ? GRAV_MIN : GRAV_BASE - grav_dec;

  // >= keeps the counter from running past the terminal value when the level rises mid-period
  assign grav_run  = (state_q != IDLE) && !bus.pause;
  assign grav_tick = grav_run && (grav_cnt_q >= grav_period - 32'd1);
  // A tick can be issued in the cycle it occurs, so the DOWN cadence equals the period
  assign down_req  = down_q || grav_tick;

  assign can_issue = (state_q == READY) && eng_wait && !bus.pause;

  // Fixed-priority pick among pending requests
  always_comb begin
    sel_cmd = ST_NONE;
    if (drop_q)                 sel_cmd = ST_DROP;
    else if (hold_q)            sel_cmd = ST_HOLD;
    else if (rot_q)             sel_cmd = ST_ROTATE;
    else if (rot_rev_q)         sel_cmd = ST_ROTATE_REV;
    else if (left_q)            sel_cmd = ST_LEFT;
    else if (right_q)           sel_cmd = ST_RIGHT;
    else if (down_req)          sel_cmd = ST_DOWN;
    else if (bar_cnt_q != 5'd0) sel_cmd = ST_BAR;
  end

  assign issue       = can_issue && (sel_cmd != ST_NONE);
  assign iss_drop    = issue && (sel_cmd == ST_DROP);
  assign iss_hold    = issue && (sel_cmd == ST_HOLD);
  assign iss_rot     = issue && (sel_cmd == ST_ROTATE);
  assign iss_rot_rev = issue && (sel_cmd == ST_ROTATE_REV);
  assign iss_left    = issue && (sel_cmd == ST_LEFT);
  assign iss_right   = issue && (sel_cmd == ST_RIGHT);
  assign iss_down    = issue && (sel_cmd == ST_DOWN);
  assign iss_bar     = issue && (sel_cmd == ST_BAR);

  // Opposite moves cancel each other whenever both would end up pending
  assign left_n  = (left_q  && !iss_left)  || bus.btn_evt[B_LEFT];
  assign right_n = (right_q && !iss_right) || bus.btn_evt[B_RIGHT];

  // Garbage row: all cells filled except one pseudo-random hole
  assign lfsr_mod = lfsr_q % 10'd10;
  assign bar_row  = 10'h3FF & ~(10'd1 << lfsr_mod);

  // Scheduler state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Scheduler next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (eng_wait) state_d = READY;
      READY: begin
        if (eng_off)    state_d = IDLE;
        else if (issue) state_d = ISSUED;
      end
      ISSUED:  state_d = BUSY;
      BUSY: begin
        if (eng_wait)     state_d = READY;
        else if (eng_off) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler outputs: next command and the busy indication
  always_comb begin
    ctrl_d = ST_NONE;
    busy_d = 1'b0;
    case (state_q)
      IDLE:         if (bus.btn_evt[B_START]) ctrl_d = ST_DOWN;
      READY:        if (issue) ctrl_d = sel_cmd;
      ISSUED, BUSY: busy_d = 1'b1;
      default:      ;
    endcase
  end

  // Registered command pulse, garbage row and level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= ST_NONE;
      bar_mask_q <= 10'd0;
      level_q    <= 4'd0;
    end else begin
      ctrl_q  <= ctrl_d;
      level_q <= level_d;
      if (iss_bar) bar_mask_q <= bar_row;
    end
  end

  // Sticky request flags: set by pulses, cleared on issue, a new pulse wins over the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q    <= 1'b0;
      hold_q    <= 1'b0;
      rot_q     <= 1'b0;
      rot_rev_q <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      down_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      drop_q    <= 1'b0;
      hold_q    <= 1'b0;
      rot_q     <= 1'b0;
      rot_rev_q <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      drop_q    <= (drop_q    && !iss_drop)    || bus.btn_evt[B_DROP];
      hold_q    <= (hold_q    && !iss_hold)    || bus.btn_evt[B_HOLD];
      rot_q     <= (rot_q     && !iss_rot)     || bus.btn_evt[B_ROTATE];
      rot_rev_q <= (rot_rev_q && !iss_rot_rev) || bus.btn_evt[B_ROTATE_REV];
      left_q    <= left_n  && !right_n;
      right_q   <= right_n && !left_n;
      down_q    <= (down_req  && !iss_down)    || bus.btn_evt[B_DOWN];
    end
  end

  // Pending garbage-row count, saturating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_cnt_q <= 5'd0;
    end else if (state_q == IDLE) begin
      bar_cnt_q <= 5'd0;
    end else if (iss_bar && !bus.bar_req) begin
      bar_cnt_q <= bar_cnt_q - 5'd1;
    end else if (!iss_bar && bus.bar_req && (bar_cnt_q < BAR_MAX)) begin
      bar_cnt_q <= bar_cnt_q + 5'd1;
    end
  end

  // Gravity counter: restarts on any downward move so gravity never doubles up on the player
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grav_cnt_q <= 32'd0;
    end else if (state_q == IDLE) begin
      grav_cnt_q <= 32'd0;
    end else if (iss_down || iss_drop) begin
      grav_cnt_q <= 32'd0;
    end else if (grav_run) begin
      grav_cnt_q <= grav_tick ? 32'd0 : grav_cnt_q + 32'd1;
    end
  end

  // Free-running 10-bit Fibonacci LFSR (taps 10,7) for the hole position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  assign bus.ctrl     = ctrl_q;
  assign bus.bar_mask = bar_mask_q;
  assign bus.level    = level_q;
  assign bus.busy     = busy_d;

endmodule

// File: tb/tb_tetris_cmd_sched.sv
// tb/tb_tetris_cmd_sched.sv - directed self-checking bench for tetris_cmd_sched
module tb_tetris_cmd_sched;

  localparam logic [3:0] NONE   = 4'd0;
  localparam logic [3:0] LEFT   = 4'd1;
  localparam logic [3:0] RIGHT  = 4'd2;
  localparam logic [3:0] ROTATE = 4'd3;
  localparam logic [3:0] DOWN   = 4'd5;
  localparam logic [3:0] DROP   = 4'd6;
  localparam logic [3:0] HOLD   = 4'd7;
  localparam logic [3:0] BAR    = 4'd8;
  localparam logic [3:0] INIT   = 4'd9;
  localparam logic [3:0] WAIT   = 4'd10;
  localparam logic [3:0] MOVE   = 4'd12;

  logic clk = 1'b0;
  logic reset_n;

  tetris_cmd_sched_if bus();

  tetris_cmd_sched #(
    .GRAV_BASE(32'd100),
    .GRAV_STEP(32'd10),
    .GRAV_MIN (32'd20),
    .BAR_MAX  (5'd20)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit auto_eng = 1'b0;
  int eng_hold = 0;
  logic [3:0] ev_cmd[$];
  int         ev_cyc[$];
  logic [9:0] ev_mask[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ev();
    ev_cmd.delete();
    ev_cyc.delete();
    ev_mask.delete();
  endtask

  // One clock; sample 1ns after the edge, log commands, optionally emulate the engine
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ctrl !== NONE) begin
      ev_cmd.push_back(bus.ctrl);
      ev_cyc.push_back(cyc);
      ev_mask.push_back(bus.bar_mask);
    end
    if (auto_eng) begin
      if (bus.ctrl !== NONE) begin
        bus.eng_state = MOVE;
        eng_hold = 2;
      end else if (eng_hold > 0) begin
        eng_hold--;
        if (eng_hold == 0) bus.eng_state = WAIT;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int bad;
    int nb;
    reset_n       = 1'b0;
    bus.eng_state = INIT;
    bus.score     = 16'h0000;
    bus.btn_evt   = 8'h00;
    bus.bar_req   = 1'b0;
    bus.pause     = 1'b0;
    #2;
    chk("reset_ctrl", bus.ctrl, NONE);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_bar_mask", bus.bar_mask, 10'h000);
    chk("reset_level", bus.level, 4'd0);
    run(2);
    reset_n = 1'b1;
    tick();

    // START in IDLE gives a single DOWN
    bus.btn_evt = 8'h80;
    tick();
    chk("start_down", bus.ctrl, DOWN);
    bus.btn_evt = 8'h00;
    tick();
    chk("start_down_one_cycle", bus.ctrl, NONE);
    bus.eng_state = WAIT;
    run(2);
    chk("ready_ctrl_none", bus.ctrl, NONE);
    chk("ready_not_busy", bus.busy, 1'b0);

    // LEFT + ROTATE together: ROTATE first, LEFT on the next WAIT
    bus.btn_evt = 8'h05;
    tick();
    bus.btn_evt = 8'h00;
    tick();
    chk("prio_rotate", bus.ctrl, ROTATE);
    chk("issued_busy", bus.busy, 1'b1);
    bus.eng_state = MOVE;
    tick();
    chk("rotate_one_cycle", bus.ctrl, NONE);
    bus.eng_state = WAIT;
    tick();
    tick();
    chk("then_left", bus.ctrl, LEFT);
    bus.eng_state = MOVE;
    tick();
    bus.eng_state = WAIT;
    run(2);
    auto_eng = 1'b1;
    eng_hold = 0;

    // Gravity at level 3: period 70
    bus.score = 16'h0300;
    clear_ev();
    run(300);
    chk("level3", bus.level, 4'd3);
    bad = 0;
    foreach (ev_cmd[i]) if (ev_cmd[i] !== DOWN) bad++;
    chk("grav70_only_down", bad, 0);
    chk("grav70_enough", ev_cyc.size() >= 3, 1'b1);
    for (int i = 1; i < ev_cyc.size(); i++) chk("grav70_interval", ev_cyc[i] - ev_cyc[i-1], 70);

    // Gravity at level 9: floor period 20
    bus.score = 16'h0900;
    clear_ev();
    run(100);
    chk("level9", bus.level, 4'd9);
    chk("grav20_enough", ev_cyc.size() >= 3, 1'b1);
    for (int i = 1; i < ev_cyc.size(); i++) chk("grav20_interval", ev_cyc[i] - ev_cyc[i-1], 20);

    // 25 bar requests while busy saturate at 20 pending rows
    bus.score = 16'h0000;
    auto_eng = 1'b0;
    bus.eng_state = WAIT;
    run(10);
    bus.btn_evt = 8'h40;
    tick();
    bus.btn_evt = 8'h00;
    tick();
    chk("hold_issue", bus.ctrl, HOLD);
    bus.eng_state = MOVE;
    bus.bar_req = 1'b1;
    run(25);
    bus.bar_req = 1'b0;
    chk("busy_during_bars", bus.busy, 1'b1);
    clear_ev();
    auto_eng = 1'b1;
    eng_hold = 1;
    run(200);
    nb = 0;
    foreach (ev_cmd[i]) begin
      if (ev_cmd[i] === BAR) begin
        nb++;
        chk("bar_mask_popcount", $countones(ev_mask[i]), 9);
      end
    end
    chk("bar_issue_count", nb, 20);

    // LEFT then RIGHT both pending (under pause): cancelled
    bus.pause = 1'b1;
    run(10);
    bus.btn_evt = 8'h01;
    tick();
    bus.btn_evt = 8'h02;
    tick();
    bus.btn_evt = 8'h00;
    bus.pause = 1'b0;
    clear_ev();
    run(20);
    bad = 0;
    foreach (ev_cmd[i]) if (ev_cmd[i] === LEFT || ev_cmd[i] === RIGHT) bad++;
    chk("lr_pending_cancel", bad, 0);

    // LEFT and RIGHT in the same cycle: cancelled
    clear_ev();
    bus.btn_evt = 8'h03;
    tick();
    bus.btn_evt = 8'h00;
    run(20);
    bad = 0;
    foreach (ev_cmd[i]) if (ev_cmd[i] === LEFT || ev_cmd[i] === RIGHT) bad++;
    chk("lr_same_cycle_cancel", bad, 0);

    // DROP held by pause, issued one cycle after release
    bus.pause = 1'b1;
    run(10);
    clear_ev();
    bus.btn_evt = 8'h20;
    tick();
    bus.btn_evt = 8'h00;
    run(8);
    chk("pause_holds_issue", ev_cmd.size(), 0);
    chk("pause_ctrl_none", bus.ctrl, NONE);
    bus.pause = 1'b0;
    tick();
    chk("drop_after_unpause", bus.ctrl, DROP);
    auto_eng = 1'b0;

    // Reset while busy with a DROP and a LEFT pending
    bus.score = 16'h0500;
    bus.btn_evt = 8'h01;
    tick();
    bus.btn_evt = 8'h00;
    tick();
    chk("busy_mid_drop", bus.busy, 1'b1);
    chk("level5", bus.level, 4'd5);
    reset_n = 1'b0;
    #1;
    chk("async_reset_ctrl", bus.ctrl, NONE);
    chk("async_reset_busy", bus.busy, 1'b0);
    chk("async_reset_level", bus.level, 4'd0);
    chk("async_reset_bar_mask", bus.bar_mask, 10'h000);
    run(2);
    reset_n = 1'b1;
    bus.eng_state = WAIT;
    clear_ev();
    run(30);
    chk("flags_cleared_by_reset", ev_cmd.size(), 0);
    chk("post_reset_not_busy", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
